// File: rtl/lc3_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_ctrl_if
//  Description : CPU-side memory bus between the LC-3 datapath (MAR/MDR,
//                control FSM) and the memory/IO access unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface lc3_mem_ctrl_if;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] MEM_OUT;
    logic        R;

    modport master (output MAR, MDR, MIO_EN, R_W, input MEM_OUT, R);
    modport slave  (input MAR, MDR, MIO_EN, R_W, output MEM_OUT, R);
endinterface
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_ctrl
//  Description : LC-3 memory/IO access unit. Word RAM plus keyboard
//                (KBSR/KBDR) and display (DSR/DDR) device registers, one
//                multi-cycle access per MIO_EN request with ready strobe R.
//                Optional Machine Control Register at xFFFE and RUN output
//                when LC3_MEM_MCR_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_ctrl #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 2
) (
    input  wire logic        i_Clk,
    input  wire logic        i_Reset,
    lc3_mem_ctrl_if.slave    bus,
    input  wire logic [7:0]  KB_DATA,
    input  wire logic        KB_VALID,
    output logic      [7:0]  DDR_OUT,
    output logic             DDR_VALID,
    input  wire logic        DISP_ACK
`ifdef LC3_MEM_MCR_EN
    ,
    output logic             RUN
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
`ifdef LC3_MEM_MCR_EN
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
`endif

    localparam int         RAM_WORDS = 1 << MEM_AW;
    // Terminal value of the wait counter; unused when LATENCY is zero
    localparam logic [3:0] LAST_CNT  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [3:0]  wait_cnt;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        rw_q;
    logic        fire;
    logic        r_pulse;
    logic [15:0] acc_addr;
    logic [15:0] acc_data;
    logic        acc_rw;
    logic        is_ram;
    logic [15:0] rd_data;
    logic [15:0] mem_out_q;
    logic        kb_ready;
    logic [7:0]  kbdr;
    logic        wr_fire;
    logic [15:0] ram [RAM_WORDS];
`ifdef LC3_MEM_MCR_EN
    logic [15:0] mcr;
`endif

    // With zero latency the access happens on the sampling edge itself,
    // so the live bus is used instead of the (not yet loaded) latches
    assign acc_addr = (LATENCY == 0) ? bus.MAR    : addr_q;
    assign acc_data = (LATENCY == 0) ? bus.MDR    : data_q;
    assign acc_rw   = (LATENCY == 0) ? bus.R_W    : rw_q;
    assign is_ram   = ({16'd0, acc_addr} < 32'(RAM_WORDS));
    // Reset on the access edge aborts the access: nothing is committed
    assign wr_fire  = fire && acc_rw && !i_Reset;

    assign bus.MEM_OUT = mem_out_q;
    assign bus.R       = r_pulse;

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Reset) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Next-state logic; RELEASE waits for MIO_EN to drop so a held request runs once
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (bus.MIO_EN) next_state = (LATENCY == 0) ? ST_DONE : ST_WAIT;
            ST_WAIT:    if (wait_cnt == LAST_CNT) next_state = ST_DONE;
            ST_DONE:    next_state = ST_RELEASE;
            ST_RELEASE: if (!bus.MIO_EN) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: access strobe on the final wait edge, ready pulse in DONE
    always_comb begin
        fire    = 1'b0;
        r_pulse = 1'b0;
        case (state)
            ST_IDLE: fire    = (LATENCY == 0) && bus.MIO_EN;
            ST_WAIT: fire    = (wait_cnt == LAST_CNT);
            ST_DONE: r_pulse = 1'b1;
            default: ;
        endcase
    end

    // Wait counter restarts every time the FSM sits in IDLE
    always_ff @(posedge i_Clk) begin
        if (i_Reset)                                        wait_cnt <= 4'd0;
        else if (state == ST_IDLE)                          wait_cnt <= 4'd0;
        else if (state == ST_WAIT && wait_cnt != LAST_CNT)  wait_cnt <= wait_cnt + 4'd1;
    end

    // Capture the request on the edge that accepts it
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            addr_q <= 16'h0000;
            data_q <= 16'h0000;
            rw_q   <= 1'b0;
        end else if (state == ST_IDLE && bus.MIO_EN) begin
            addr_q <= bus.MAR;
            data_q <= bus.MDR;
            rw_q   <= bus.R_W;
        end
    end

    // Word RAM write port (contents are never reset)
    always_ff @(posedge i_Clk) begin
        if (wr_fire && is_ram) ram[acc_addr[MEM_AW-1:0]] <= acc_data;
    end

    // Read data decode on the latched address; unmapped locations read 0
    always_comb begin
        rd_data = 16'h0000;
        if (is_ram) begin
            rd_data = ram[acc_addr[MEM_AW-1:0]];
        end else begin
            case (acc_addr)
                KBSR_ADDR: rd_data = {kb_ready, 15'd0};
                KBDR_ADDR: rd_data = {8'd0, kbdr};
                DSR_ADDR:  rd_data = {~DDR_VALID, 15'd0};
                DDR_ADDR:  rd_data = {8'd0, DDR_OUT};
`ifdef LC3_MEM_MCR_EN
                MCR_ADDR:  rd_data = mcr;
`endif
                default:   rd_data = 16'h0000;
            endcase
        end
    end

    // MEM_OUT only changes when a read completes
    always_ff @(posedge i_Clk) begin
        if (i_Reset)                mem_out_q <= 16'h0000;
        else if (fire && !acc_rw)   mem_out_q <= rd_data;
    end

    // Keyboard: a new character beats the read-clear on the same edge
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            kb_ready <= 1'b0;
            kbdr     <= 8'h00;
        end else if (KB_VALID) begin
            kb_ready <= 1'b1;
            kbdr     <= KB_DATA;
        end else if (fire && !acc_rw && acc_addr == KBDR_ADDR) begin
            kb_ready <= 1'b0;
        end
    end

    // Display: a DDR write beats the consumer acknowledge on the same edge
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            DDR_OUT   <= 8'h00;
            DDR_VALID <= 1'b0;
        end else if (fire && acc_rw && acc_addr == DDR_ADDR) begin
            DDR_OUT   <= acc_data[7:0];
            DDR_VALID <= 1'b1;
        end else if (DISP_ACK) begin
            DDR_VALID <= 1'b0;
        end
    end

`ifdef LC3_MEM_MCR_EN
    // Machine Control Register; bit 15 is the clock-enable for the CPU
    always_ff @(posedge i_Clk) begin
        if (i_Reset)                                     mcr <= 16'h8000;
        else if (fire && acc_rw && acc_addr == MCR_ADDR) mcr <= acc_data;
    end

    assign RUN = mcr[15];
`endif

endmodule
`default_nettype wire
